// File: rtl/map_port_arbiter.sv
// Port-B owner for the map/candy BRAM: round-robin shares the port among the
// requesters and performs an atomic read / consume (read-modify-write) access.
module map_port_arbiter #(
    parameter int unsigned       N_REQ       = 5,
    parameter int unsigned       ADDR_W      = 11,
    parameter int unsigned       DEPTH       = 1152,
    parameter int unsigned       DATA_W      = 4,
    parameter logic [DATA_W-1:0] CANDY_TILE  = DATA_W'(1),
    parameter logic [DATA_W-1:0] COOKIE_TILE = DATA_W'(2),
    parameter logic [DATA_W-1:0] EMPTY_TILE  = DATA_W'(0),
    parameter logic [DATA_W-1:0] WALL_TILE   = DATA_W'(4'hF)
) (
    input  logic                     vga_pix_clk,
    input  logic                     rst,
    input  logic                     hold,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         consume,
    input  logic [N_REQ*ADDR_W-1:0]  addr,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     ate_candy_stb,
    output logic                     ate_cookie_stb,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_din,
    input  logic [DATA_W-1:0]        mem_dout
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        WRITEBACK,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                op_q, op_d;
    logic                oor_q, oor_d;
    logic [DATA_W-1:0]   tile_q, tile_d;

    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                candy_q, candy_d;
    logic                cookie_q, cookie_d;
    logic                we_q, we_d;

    logic [ADDR_W-1:0]   addr_arr [N_REQ];
    logic                found;
    logic [IDX_W-1:0]    win;
    int unsigned         cand;
    logic [IDX_W-1:0]    cand_idx;
    logic                consumable;

    // Split the packed address bus into one slice per requester.
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g] = addr[g*ADDR_W +: ADDR_W];
    end

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                win   = cand_idx;
            end
        end
    end

    // A consume only rewrites tiles that are actually edible.
    assign consumable = op_q && !oor_q &&
                        ((mem_dout == CANDY_TILE) || (mem_dout == COOKIE_TILE));

    // Next-state and next-output decode; outputs are registered from these.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        op_d     = op_q;
        oor_d    = oor_q;
        tile_d   = tile_q;
        gnt_d    = '0;
        rvalid_d = '0;
        rdata_d  = '0;
        candy_d  = 1'b0;
        cookie_d = 1'b0;
        we_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!hold && found) begin
                    idx_d      = win;
                    addr_d     = addr_arr[win];
                    op_d       = consume[win];
                    oor_d      = (32'(addr_arr[win]) >= DEPTH);
                    gnt_d[win] = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                tile_d = oor_q ? WALL_TILE : mem_dout;
                if (consumable) begin
                    we_d    = 1'b1;
                    state_d = WRITEBACK;
                end else begin
                    rvalid_d[idx_q] = 1'b1;
                    rdata_d         = tile_d;
                    state_d         = RESP;
                end
            end
            WRITEBACK: begin
                rvalid_d[idx_q] = 1'b1;
                rdata_d         = tile_q;
                candy_d         = (tile_q == CANDY_TILE);
                cookie_d        = (tile_q == COOKIE_TILE) && (tile_q != CANDY_TILE);
                state_d         = RESP;
            end
            RESP: begin
                rr_ptr_d = (32'(idx_q) == N_REQ - 1) ? '0 : idx_q + IDX_W'(1);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, access latches and registered outputs; reset aborts any access.
    always_ff @(posedge vga_pix_clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            op_q     <= 1'b0;
            oor_q    <= 1'b0;
            tile_q   <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            candy_q  <= 1'b0;
            cookie_q <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            op_q     <= op_d;
            oor_q    <= oor_d;
            tile_q   <= tile_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            candy_q  <= candy_d;
            cookie_q <= cookie_d;
            we_q     <= we_d;
        end
    end

    assign gnt            = gnt_q;
    assign rvalid         = rvalid_q;
    assign rdata          = rdata_q;
    assign ate_candy_stb  = candy_q;
    assign ate_cookie_stb = cookie_q;
    assign mem_addr       = addr_q;
    assign mem_we         = we_q;
    assign mem_din        = EMPTY_TILE;

endmodule

// File: doc/map_port_arbiter.md
Name: map_port_arbiter

Overview:
- Owns port B of the map/candy dual-port BRAM and shares it among up to N_REQ requesters: index 0 is Pac-Man, indices 1..4 are the ghosts (wall lookups).
- Serialises accesses with a round-robin arbiter.
- Performs an atomic "consume" read-modify-write: read the tile, replace candy/cookie with empty, pulse exactly one eat strobe.
- Replaces the ad-hoc strobe-suppression logic around port B and feeds score/frightened-mode logic.

Parameters:
- N_REQ, 5, number of requesters (2..8).
- ADDR_W, 11, map tile address width (32*36 = 1152 tiles).
- DEPTH, 1152, valid addresses 0..DEPTH-1.
- DATA_W, 4, tile code width.
- CANDY_TILE, params::map::candy_tile, tile code of a candy.
- COOKIE_TILE, params::map::cookie_tile, tile code of a power cookie.
- EMPTY_TILE, params::map::empty_tile, code written back after consume.
- WALL_TILE, 4'hF, code returned for out-of-range addresses.

Ports:
- vga_pix_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  blocks new grants; an in-flight access completes.
- req  in  N_REQ  per-requester access request (level).
- consume  in  N_REQ  per-requester op: 1 = read-modify-write, 0 = read. Ghosts tie 0.
- addr  in  N_REQ*ADDR_W  packed tile addresses; slice i belongs to requester i.
- gnt  out  N_REQ  one-hot, one-cycle pulse when the access is issued.
- rvalid  out  N_REQ  one-hot, one-cycle pulse with the response.
- rdata  out  DATA_W  original tile read; qualified by rvalid.
- ate_candy_stb  out  1  one-cycle pulse when a consume removed a candy.
- ate_cookie_stb  out  1  one-cycle pulse when a consume removed a cookie.
- mem_addr  out  ADDR_W  BRAM port B address.
- mem_we  out  1  BRAM port B write enable.
- mem_din  out  DATA_W  BRAM port B write data.
- mem_dout  in  DATA_W  BRAM port B read data, valid one clock after the address.

Behaviour:
- Single clock vga_pix_clk; reset asynchronous, active-high.
- Reset forces: state=IDLE, rr_ptr=0, all latches 0. All outputs are 0 during and after reset.
- Reset mid-access aborts it: no write, no rvalid, no strobe is emitted afterwards.
- All outputs are decoded from registered state/latches. No combinational path from req/addr to outputs.

FSM states: IDLE, ISSUE, CAPTURE, WRITEBACK, RESP.
- IDLE:
  - If hold=0 and |req, the winner is the first i with req[i]=1, searching from rr_ptr upward with wrap.
  - Latch idx_q, addr_q, op_q=consume[idx_q] and oor_q=(addr_q>=DEPTH); go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle): mem_addr=addr_q, mem_we=0, gnt[idx_q]=1 → CAPTURE.
- CAPTURE (1 cycle):
  - tile_q = oor_q ? WALL_TILE : mem_dout.
  - If op_q=1, oor_q=0 and mem_dout is CANDY_TILE or COOKIE_TILE → WRITEBACK; else → RESP.
- WRITEBACK (1 cycle): mem_addr=addr_q, mem_we=1, mem_din=EMPTY_TILE → RESP.
- RESP (1 cycle):
  - rvalid[idx_q]=1, rdata=tile_q.
  - ate_candy_stb=1 iff a write-back occurred and tile_q==CANDY_TILE; ate_cookie_stb likewise for COOKIE_TILE.
  - rr_ptr <= (idx_q+1) mod N_REQ → IDLE.
- Idle outputs: mem_addr=addr_q, mem_we=0, mem_din=EMPTY_TILE whenever not in WRITEBACK.

Latency and throughput:
- req sampled high in IDLE at edge k: gnt high in cycle k+1, rvalid in cycle k+3 (read) or k+4 (consume with write-back).
- One access per 4 or 5 cycles.

Handshake:
- Requester keeps req, addr and consume stable until gnt; it may drop req after gnt.
- Once latched, an access always completes, even if req drops.
- A requester holding req continuously is re-granted only after every other pending requester has been served once (round-robin fairness).

Boundaries:
- Consume of a non-candy/non-cookie tile: no write, no strobe; rdata = tile.
- Out-of-range address: never written; rdata = WALL_TILE.
- hold rising during ISSUE..RESP does not stall that access. hold only gates the IDLE decision.
- rr_ptr wraps from N_REQ-1 to 0.
- At most one eat strobe per access; never both strobes together.

Test Plan:
(Bench overrides CANDY_TILE=1, COOKIE_TILE=2, EMPTY_TILE=0, WALL_TILE=4'hF; BRAM model preloaded.)
- Read: req[2]=1, addr=100 (holds 3) → gnt=5'b00100 at +1, rvalid[2] at +3, rdata=3, mem_we never 1.
- Consume candy: req[0], consume[0]=1, addr=33 (holds 1) → mem_we=1 with mem_addr=33, mem_din=0 at +3; rvalid[0] and ate_candy_stb at +4. A repeat consume of 33 returns 0 with no strobe.
- Consume cookie at addr=65 (holds 2) → ate_cookie_stb pulses once, ate_candy_stb stays 0. Consume of a wall (value 4'hF) → no write, no strobe.
- Fairness: req=5'b11111 held for 25 cycles → grants in order 0,1,2,3,4; rr_ptr back to 0.
- Boundary: addr=1200 → rdata=4'hF, no write. With hold=1 and req[1]=1 → no gnt until hold falls, then gnt at +1.
- Async rst asserted during WRITEBACK of addr=33 → mem_we drops immediately, no rvalid/strobe. After release, state=IDLE and the next grant goes to requester 0.
